inst_fetch_unit: RTL



---
 rtl/inst_fetch_unit.sv | 79 +++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC generation and instruction fetch with one outstanding request and a one-entry skid register
module inst_fetch_unit #(
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  system_stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic [INST_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  uop_valid_out
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, FULL, DROP} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] pc, req_pc, skid_pc;
  logic [INST_WIDTH-1:0] skid_inst;
  logic take, out_free, redirect;
  assign take = uop_valid_out & ~system_stall;
  assign out_free = ~uop_valid_out | take;
  assign redirect = redirect_valid & (state != IDLE);
  assign imem_req = state == FETCH;
  assign imem_addr = pc;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      req_pc <= RESET_PC;
      skid_pc <= '0;
      skid_inst <= '0;
      instruction <= '0;
      inst_pc <= '0;
      uop_valid_out <= 1'b0;
    end else if (redirect) begin
      pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      uop_valid_out <= 1'b0;
      state <= (state == FULL) || (state == FETCH && !imem_gnt) ||
               ((state == WAIT || state == DROP) && imem_rvalid) ? FETCH : DROP;
    end else begin
      if (take)
        uop_valid_out <= 1'b0;
      case (state)
        IDLE: state <= FETCH;
        FETCH: if (imem_gnt) begin
          pc <= pc + ADDR_WIDTH'(4);
          req_pc <= pc;
          state <= WAIT;
        end
        WAIT: if (imem_rvalid) begin
          if (out_free) begin
            instruction <= imem_rdata;
            inst_pc <= req_pc;
            uop_valid_out <= 1'b1;
          end else begin
            skid_inst <= imem_rdata;
            skid_pc <= req_pc;
          end
          state <= out_free ? FETCH : FULL;
        end
        FULL: if (take) begin
          instruction <= skid_inst;
          inst_pc <= skid_pc;
          uop_valid_out <= 1'b1;
          state <= FETCH;
        end
        DROP: if (imem_rvalid)
          state <= FETCH;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
